// File: rtl/result_row_streamer_pkg.sv
// Shared types and sizes for the result row streamer.
// Row width Rw = PartialSumBw * MatrixSize. FSM state enum, row index/count types and
// the buffered row entry {data, last, row_idx}.
package result_row_streamer_pkg;

  localparam int unsigned AddrSize     = 10;
  localparam int unsigned PartialSumBw = 24;
  localparam int unsigned MatrixSize   = 128;
  localparam int unsigned Rw           = PartialSumBw * MatrixSize;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  typedef logic [AddrSize-1:0] row_idx_t;
  // One extra bit so a full 2^AddrSize row count fits.
  typedef logic [AddrSize:0]   row_cnt_t;

  typedef struct packed {
    logic [Rw-1:0] data;
    logic          last;
    row_idx_t      row_idx;
  } row_entry_t;

endpackage

// File: rtl/result_row_streamer_if.sv
// Valid/ready row stream carrying one result row per beat.
//   valid   : row valid (master)
//   ready   : downstream accepts when valid && ready (slave)
//   data    : result row, Rw bits
//   last    : high with the final row of a run
//   row_idx : 0-based row index of the beat
interface result_row_streamer_if;

  logic                                valid;
  logic                                ready;
  logic [result_row_streamer_pkg::Rw-1:0] data;
  logic                                last;
  result_row_streamer_pkg::row_idx_t   row_idx;

  modport master (output valid, output data, output last, output row_idx, input ready);
  modport slave  (input valid, input data, input last, input row_idx, output ready);

endinterface

// File: rtl/result_row_streamer_skid_fifo.sv
// Two-entry synchronous FIFO holding buffered result rows.
//   clk, rstn : clock, asynchronous active-low reset
//   push_i    : write entry_i (accepted when not full, or when full with a pop)
//   entry_i   : row entry to write
//   pop_i     : remove head entry (ignored when empty)
//   entry_o   : head entry
//   valid_o   : FIFO not empty
//   count_o   : number of entries held (0..2)
module result_row_streamer_skid_fifo
  import result_row_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  row_entry_t entry_i,
  input  logic       pop_i,
  output row_entry_t entry_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  row_entry_t mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign entry_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/result_row_streamer.sv
// Walks the result SRAM from base_addr for num_rows rows after a start pulse and streams
// each row over a valid/ready port, absorbing read latency and backpressure in a
// two-entry buffer.
//   clk, rstn    : clock, asynchronous active-low reset
//   start_i      : 1-cycle pulse, latches base_addr_i / num_rows_i when idle
//   base_addr_i  : first row address
//   num_rows_i   : rows to stream, 0..2^AddrSize
//   busy_o       : run in progress
//   done_o       : 1-cycle pulse after the last beat handshakes
//   start_err_o  : sticky, start seen while busy
//   rd_en_o      : SRAM read strobe; rd_addr_o address; rd_data_i valid 1 cycle later
//   m_if         : row stream (master)
module result_row_streamer
  import result_row_streamer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  row_idx_t               base_addr_i,
  input  row_cnt_t               num_rows_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   start_err_o,
  output logic                   rd_en_o,
  output row_idx_t               rd_addr_o,
  input  logic [Rw-1:0]          rd_data_i,
  result_row_streamer_if.master  m_if
);

  state_e     state_q, state_d;
  row_idx_t   base_q, base_d;
  row_cnt_t   num_q, num_d;
  row_cnt_t   issued_q, issued_d;
  logic       inflight_q;
  row_idx_t   inflight_idx_q;
  logic       start_err_q;
  logic       rd_en, busy, pop;
  logic [1:0] buf_count;
  logic       buf_valid;
  logic [2:0] occupancy;
  row_entry_t push_entry, head_entry;

  assign busy = (state_q == StRead) || (state_q == StDrain);
  assign pop  = buf_valid && m_if.ready;
  // Rows the buffer will hold next cycle if nothing new is issued now.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    issued_d = issued_q;
    rd_en    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (start_i) begin
          base_d   = base_addr_i;
          num_d    = num_rows_i;
          issued_d = '0;
          state_d  = (num_rows_i == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        rd_en = (issued_q < num_q) && (occupancy < 3'd2);
        if (rd_en) issued_d = issued_q + row_cnt_t'(1);
        if (issued_d == num_q) state_d = StDrain;
      end
      StDrain: begin
        // No reads are issued here, so zero occupancy means empty with nothing in flight.
        if (occupancy == 3'd0) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      base_q         <= '0;
      num_q          <= '0;
      issued_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      start_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      inflight_q <= rd_en;
      if (rd_en) inflight_idx_q <= issued_q[AddrSize-1:0];
      if (start_i && busy) start_err_q <= 1'b1;
    end
  end

  assign push_entry.data    = rd_data_i;
  assign push_entry.last    = ({1'b0, inflight_idx_q} == (num_q - row_cnt_t'(1)));
  assign push_entry.row_idx = inflight_idx_q;

  result_row_streamer_skid_fifo u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (inflight_q),
    .entry_i (push_entry),
    .pop_i   (pop),
    .entry_o (head_entry),
    .valid_o (buf_valid),
    .count_o (buf_count)
  );

  assign busy_o       = busy;
  assign done_o       = (state_q == StDone);
  assign start_err_o  = start_err_q;
  assign rd_en_o      = rd_en;
  assign rd_addr_o    = base_q + issued_q[AddrSize-1:0];
  assign m_if.valid   = buf_valid;
  assign m_if.data    = head_entry.data;
  assign m_if.last    = head_entry.last;
  assign m_if.row_idx = head_entry.row_idx;

endmodule
